alu_rr_arbiter: RTL and testbench
=================================

// Module: alu_rr_arbiter
// PURPOSE
//  Shares one clocked 8-bit ALU (alu_8_bit) between two requesters with round-robin arbitration.
//  Accepts operand/opcode requests on valid/ready channels and drives the ALU operand/opcode
//  inputs from registers. Waits out the ALU latency, then returns result and carry on one
//  shared response channel tagged with the requester id. Sits between the two ALU clients
//  and the alu_8_bit instance.
// PARAMETERS
//  WIDTH    8     operand/result width
//  OPW      4     opcode width
//  ALU_LAT  1     ALU clock cycles from stable inputs to valid alu_out/carry_out (>=1)
//  MAX_OP   4'hA  highest legal opcode; op > MAX_OP is rejected with an error response
// PORTS
//  clk        in   1      clock, rising edge
//  rst        in   1      synchronous, active-high reset
//  req0_valid in   1      requester 0 has a request
//  req0_ready out  1      arbiter accepts requester 0 this cycle
//  req0_a     in   WIDTH  requester 0 operand A
//  req0_b     in   WIDTH  requester 0 operand B
//  req0_op    in   OPW    requester 0 opcode
//  req1_*     --   --     same set for requester 1 (valid/ready/a/b/op)
//  alu_a      out  WIDTH  to ALU in_a (registered)
//  alu_b      out  WIDTH  to ALU in_b (registered)
//  alu_op     out  OPW    to ALU opCode (registered)
//  alu_res    in   WIDTH  from ALU alu_out
//  alu_cy     in   1      from ALU carry_out
//  rsp_valid  out  1      response available
//  rsp_ready  in   1      consumer takes response
//  rsp_id     out  1      requester the response belongs to
//  rsp_data   out  WIDTH  captured ALU result (0 on error)
//  rsp_carry  out  1      captured ALU carry (0 on error)
//  rsp_err    out  1      1 = illegal opcode, ALU not used
// BEHAVIOUR
//  - Reset: state IDLE, prio=0, all outputs 0 (ready, rsp_*, alu_a/b/op).
//  - One clock (clk). Reset is synchronous, active-high (rst) and overrides everything.
//    An in-flight op is dropped and no response is issued.
//  - FSM: IDLE -> EXEC -> RESP -> IDLE. Illegal op: IDLE -> RESP directly.
//  - IDLE: sel = prio if req[prio]_valid, else the other requester if valid.
//    reqN_ready = (state==IDLE) && (sel==N) && reqN_valid (combinational).
//    Not ready outside IDLE.
//  - Accept edge (valid&&ready at edge T): latch id.
//    Legal op: alu_a/b/op <= req operands; cnt <= ALU_LAT; go EXEC.
//    Illegal op: rsp_err=1, data/carry=0, alu_* unchanged; go RESP.
//    In both cases prio <= ~sel.
//  - Both valid in IDLE: prio wins. Only one valid: it wins regardless of prio.
//  - EXEC: alu_* held stable. cnt decrements each cycle.
//    On the edge where cnt==0: rsp_data<=alu_res, rsp_carry<=alu_cy, rsp_err<=0; go RESP.
//    EXEC lasts ALU_LAT+1 cycles.
//    Accept-edge to rsp_valid high = ALU_LAT+2 cycles (3 for ALU_LAT=1).
//  - RESP: rsp_valid=1; rsp_id/data/carry/err held stable until rsp_valid&&rsp_ready.
//    Then go IDLE next cycle. No same-cycle accept of a new request (no bypass).
//  - Back-pressure: rsp_ready low holds RESP indefinitely. Requests wait; none are lost.
//  - alu_a/b/op keep their last values between ops.
//  - A requester may drop valid before ready with no effect.
// TESTING
//  1 req0: a=8'hAA b=8'h55 op=0000 (ADD) -> ready0 1 cycle; alu_op=0000 next cycle;
//    rsp_valid 3 cycles after accept, id=0, data=8'hFF, carry=0.
//  2 req1: a=8'hE3 b=8'h7D op=0000 -> rsp id=1, data=8'h60, carry=1.
//  3 Both valid continuously, rsp_ready=1 -> grants alternate 0,1,0,1 from reset; no starvation.
//  4 req0 op=4'hB -> rsp_err=1, data=0, carry=0, id=0, 1 cycle after accept; alu_* unchanged.
//  5 rsp_ready=0 for 5 cycles -> rsp fields stable; req1_ready stays 0; released 1 cycle
//    after rsp_ready rises.
//  6 rst in EXEC -> next cycle state IDLE, rsp_valid=0, alu_*=0, prio=0; no stale response.

Source files
------------

// File: rtl/alu_rr_arbiter.sv
// alu_rr_arbiter
//   Shares one clocked ALU between two requesters using round-robin arbitration.
//   A request is accepted on a valid/ready handshake. The arbiter registers its
//   operands onto the ALU inputs and waits out the ALU latency. It then returns
//   the result and carry on a single response channel, tagged with the id of the
//   requester. An opcode above MAX_OP never reaches the ALU; it is answered with
//   an error response instead.
//
// Ports
//   clk, rst                   clock (rising edge), synchronous active-high reset
//   req0_valid/ready/a/b/op    requester 0 channel
//   req1_valid/ready/a/b/op    requester 1 channel
//   alu_a, alu_b, alu_op       registered operands/opcode driven to the ALU
//   alu_res, alu_cy            ALU result and carry
//   rsp_valid/ready            response handshake
//   rsp_id                     requester the response belongs to
//   rsp_data, rsp_carry        captured ALU result/carry (0 on error)
//   rsp_err                    illegal opcode, ALU not used
module alu_rr_arbiter #(
    parameter int unsigned     WIDTH   = 8,
    parameter int unsigned     OPW     = 4,
    parameter int unsigned     ALU_LAT = 1,
    parameter logic [OPW-1:0]  MAX_OP  = 4'hA
) (
    input  logic             clk,
    input  logic             rst,

    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [OPW-1:0]   req0_op,

    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [OPW-1:0]   req1_op,

    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [OPW-1:0]   alu_op,
    input  logic [WIDTH-1:0] alu_res,
    input  logic             alu_cy,

    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_data,
    output logic             rsp_carry,
    output logic             rsp_err
);

    localparam int unsigned CW = (ALU_LAT < 1) ? 1 : $clog2(ALU_LAT + 1);

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        RESP
    } state_t;

    state_t          state;
    logic            prio;
    logic [CW-1:0]   cnt;

    logic            sel;
    logic            sel_valid;
    logic            accept;
    logic [WIDTH-1:0] sel_a;
    logic [WIDTH-1:0] sel_b;
    logic [OPW-1:0]   sel_op;

    // The priority requester wins when it is valid. Otherwise the other one
    // takes the slot, so a lone requester never waits on prio.
    always_comb begin
        sel = prio;
        if (prio) begin
            if (!req1_valid && req0_valid) sel = 1'b0;
        end else begin
            if (!req0_valid && req1_valid) sel = 1'b1;
        end
        sel_valid  = sel ? req1_valid : req0_valid;
        accept     = (state == IDLE) && sel_valid;
        req0_ready = (state == IDLE) && !sel && req0_valid;
        req1_ready = (state == IDLE) &&  sel && req1_valid;
        sel_a      = sel ? req1_a  : req0_a;
        sel_b      = sel ? req1_b  : req0_b;
        sel_op     = sel ? req1_op : req0_op;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            prio      <= 1'b0;
            cnt       <= '0;
            alu_a     <= '0;
            alu_b     <= '0;
            alu_op    <= '0;
            rsp_valid <= 1'b0;
            rsp_id    <= 1'b0;
            rsp_data  <= '0;
            rsp_carry <= 1'b0;
            rsp_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        rsp_id <= sel;
                        prio   <= ~sel;
                        if (sel_op > MAX_OP) begin
                            // Illegal opcode: answer at once and leave the ALU inputs alone.
                            rsp_err   <= 1'b1;
                            rsp_data  <= '0;
                            rsp_carry <= 1'b0;
                            rsp_valid <= 1'b1;
                            state     <= RESP;
                        end else begin
                            alu_a  <= sel_a;
                            alu_b  <= sel_b;
                            alu_op <= sel_op;
                            cnt    <= CW'(ALU_LAT);
                            state  <= EXEC;
                        end
                    end
                end
                EXEC: begin
                    // The extra cycle spent at cnt==0 covers the ALU input register
                    // stage, so the result is sampled ALU_LAT+1 cycles after launch.
                    if (cnt == '0) begin
                        rsp_data  <= alu_res;
                        rsp_carry <= alu_cy;
                        rsp_err   <= 1'b0;
                        rsp_valid <= 1'b1;
                        state     <= RESP;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_rr_arbiter.sv
module tb_alu_rr_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic       req0_valid, req0_ready, req1_valid, req1_ready;
    logic [7:0] req0_a, req0_b, req1_a, req1_b;
    logic [3:0] req0_op, req1_op;
    logic [7:0] alu_a, alu_b, alu_res;
    logic [3:0] alu_op;
    logic       alu_cy;
    logic       rsp_valid, rsp_ready, rsp_id, rsp_carry, rsp_err;
    logic [7:0] rsp_data;

    int n_pass  = 0;
    int n_total = 0;
    bit chk_en  = 1'b0;

    always #5 clk = ~clk;

    alu_rr_arbiter #(.WIDTH(8), .OPW(4), .ALU_LAT(1), .MAX_OP(4'hA)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
        .alu_res(alu_res), .alu_cy(alu_cy),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_data(rsp_data), .rsp_carry(rsp_carry), .rsp_err(rsp_err)
    );

    // Environment ALU: {carry, result} as a function of the operands.
    function automatic logic [8:0] alu_fn(input logic [7:0] a, input logic [7:0] b,
                                          input logic [3:0] op);
        case (op)
            4'h0:    return 9'(a) + 9'(b);
            4'h1:    return 9'(a) - 9'(b);
            4'h2:    return {1'b0, a & b};
            4'h3:    return {1'b0, a | b};
            4'h4:    return {1'b0, a ^ b};
            4'h5:    return {1'b0, ~a};
            4'h6:    return {a, 1'b0};
            4'h7:    return {a[0], 1'b0, a[7:1]};
            4'h8:    return 9'(a) + 9'd1;
            4'h9:    return 9'(a) - 9'd1;
            4'hA:    return {1'b0, b};
            default: return 9'd0;
        endcase
    endfunction

    // One-cycle-latency ALU.
    always @(posedge clk) {alu_cy, alu_res} <= alu_fn(alu_a, alu_b, alu_op);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual %0h required %0h", name, act, exp);
    endtask

    // ---------------- behavioural model ----------------
    // phase 0: waiting for a request, 1: ALU busy, 2: response offered
    int         m_phase = 0;
    int         m_wait  = 0;
    bit         m_prio  = 1'b0;
    bit         m_id    = 1'b0;
    logic [7:0] m_data  = '0;
    bit         m_cy    = 1'b0;
    bit         m_err   = 1'b0;
    logic [7:0] m_a     = '0;
    logic [7:0] m_b     = '0;
    logic [3:0] m_op    = '0;

    always @(negedge clk) begin
        if (chk_en) begin
            bit         any_v, g;
            logic [3:0] op;
            logic [7:0] a, b;
            logic [8:0] r;
            any_v = req0_valid || req1_valid;
            // Requester named by prio goes first if it asks; otherwise whoever asks.
            if (m_prio ? req1_valid : req0_valid) g = m_prio;
            else                                  g = ~m_prio;

            check("m_ready0", 32'(req0_ready), 32'(m_phase == 0 && any_v && g == 1'b0));
            check("m_ready1", 32'(req1_ready), 32'(m_phase == 0 && any_v && g == 1'b1));
            check("m_rsp_valid", 32'(rsp_valid), 32'(m_phase == 2));
            check("m_alu_a", 32'(alu_a), 32'(m_a));
            check("m_alu_b", 32'(alu_b), 32'(m_b));
            check("m_alu_op", 32'(alu_op), 32'(m_op));
            if (m_phase == 2) begin
                check("m_rsp_id", 32'(rsp_id), 32'(m_id));
                check("m_rsp_data", 32'(rsp_data), 32'(m_data));
                check("m_rsp_carry", 32'(rsp_carry), 32'(m_cy));
                check("m_rsp_err", 32'(rsp_err), 32'(m_err));
            end

            if (rst) begin
                m_phase = 0; m_prio = 1'b0;
                m_a = '0; m_b = '0; m_op = '0;
            end else if (m_phase == 0) begin
                if (any_v) begin
                    m_id   = g;
                    m_prio = ~g;
                    op = g ? req1_op : req0_op;
                    a  = g ? req1_a  : req0_a;
                    b  = g ? req1_b  : req0_b;
                    if (op > 4'hA) begin
                        m_err = 1'b1; m_data = '0; m_cy = 1'b0;
                        m_phase = 2;
                    end else begin
                        m_a = a; m_b = b; m_op = op;
                        r = alu_fn(a, b, op);
                        m_cy = r[8]; m_data = r[7:0]; m_err = 1'b0;
                        m_wait = 2;   // ALU_LAT + 1 busy cycles
                        m_phase = 1;
                    end
                end
            end else if (m_phase == 1) begin
                m_wait--;
                if (m_wait == 0) m_phase = 2;
            end else begin
                if (rsp_ready) m_phase = 0;
            end
        end
    end

    // ---------------- directed helpers ----------------
    task automatic clear_reqs();
        req0_valid = 1'b0; req1_valid = 1'b0;
    endtask

    task automatic do_req(input bit id, input logic [7:0] a, input logic [7:0] b,
                          input logic [3:0] op, input int exp_lat, input logic [7:0] exp_d,
                          input bit exp_c, input bit exp_e);
        int n;
        bit ok;
        @(posedge clk); #1;
        if (id == 1'b0) begin
            req0_valid = 1'b1; req0_a = a; req0_b = b; req0_op = op;
        end else begin
            req1_valid = 1'b1; req1_a = a; req1_b = b; req1_op = op;
        end
        n = 0; ok = 1'b0;
        while (!ok && n < 20) begin
            @(negedge clk); n++;
            ok = (id == 1'b0) ? req0_ready : req1_ready;
        end
        if (!ok) begin
            n_total++;
            $display("FAIL grant_timeout: requester %0d not granted within 20 cycles", id);
            clear_reqs();
            return;
        end
        check("ready_latency", 32'(n), 32'(1));
        @(posedge clk); #1;
        clear_reqs();
        n = 0;
        do begin
            @(negedge clk); n++;
            if (n == 1 && !exp_e) begin
                check("alu_a_launch", 32'(alu_a), 32'(a));
                check("alu_op_launch", 32'(alu_op), 32'(op));
            end
        end while (!rsp_valid && n < 20);
        check("rsp_latency", 32'(n), 32'(exp_lat));
        check("rsp_id", 32'(rsp_id), 32'(id));
        check("rsp_data", 32'(rsp_data), 32'(exp_d));
        check("rsp_carry", 32'(rsp_carry), 32'(exp_c));
        check("rsp_err", 32'(rsp_err), 32'(exp_e));
    endtask

    task automatic wait_grant(output bit who, output bit ok);
        int n;
        n = 0; ok = 1'b0; who = 1'b0;
        while (!ok && n < 20) begin
            @(negedge clk); n++;
            if (req0_ready || req1_ready) begin
                ok = 1'b1; who = req1_ready;
            end
        end
        if (!ok) begin
            n_total++;
            $display("FAIL grant_wait: no grant within 20 cycles");
        end
    endtask

    initial begin
        bit who, ok;
        int n;
        rst = 1'b1; rsp_ready = 1'b1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_a = '0; req0_b = '0; req0_op = '0;
        req1_a = '0; req1_b = '0; req1_op = '0;
        @(posedge clk); #1 chk_en = 1'b1;
        @(posedge clk); #1 rst = 1'b0;

        // reset state
        @(negedge clk);
        check("rst_rsp_valid", 32'(rsp_valid), 32'(0));
        check("rst_rsp_data", 32'(rsp_data), 32'(0));
        check("rst_alu_a", 32'(alu_a), 32'(0));
        check("rst_alu_op", 32'(alu_op), 32'(0));

        // single requests, legal and illegal
        do_req(1'b0, 8'hAA, 8'h55, 4'h0, 3, 8'hFF, 1'b0, 1'b0);
        do_req(1'b1, 8'hE3, 8'h7D, 4'h0, 3, 8'h60, 1'b1, 1'b0);
        do_req(1'b0, 8'h11, 8'h22, 4'hB, 1, 8'h00, 1'b0, 1'b1);
        check("err_alu_a_kept", 32'(alu_a), 32'(8'hE3));
        check("err_alu_b_kept", 32'(alu_b), 32'(8'h7D));
        check("err_alu_op_kept", 32'(alu_op), 32'(0));

        // both requesters continuously valid from reset: strict alternation
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        req0_valid = 1'b1; req0_a = 8'h01; req0_b = 8'h02; req0_op = 4'h3;
        req1_valid = 1'b1; req1_a = 8'h0F; req1_b = 8'hF0; req1_op = 4'h4;
        for (int k = 0; k < 4; k++) begin
            wait_grant(who, ok);
            if (ok) check("rr_grant_order", 32'(who), 32'(k % 2));
        end
        @(posedge clk); #1 clear_reqs();
        repeat (6) @(posedge clk);

        // back-pressure: response held while rsp_ready is low
        #1;
        rsp_ready = 1'b0;
        req0_valid = 1'b1; req0_a = 8'h10; req0_b = 8'h20; req0_op = 4'h0;
        req1_valid = 1'b1; req1_a = 8'h33; req1_b = 8'h44; req1_op = 4'h0;
        n = 0;
        do begin @(negedge clk); n++; end while (!rsp_valid && n < 20);
        check("bp_rsp_seen", 32'(rsp_valid), 32'(1));
        @(posedge clk); #1 req0_valid = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("bp_hold_valid", 32'(rsp_valid), 32'(1));
            check("bp_hold_id", 32'(rsp_id), 32'(0));
            check("bp_hold_data", 32'(rsp_data), 32'(8'h30));
            check("bp_req1_blocked", 32'(req1_ready), 32'(0));
        end
        @(posedge clk); #1 rsp_ready = 1'b1; clear_reqs();
        @(negedge clk); check("bp_still_valid", 32'(rsp_valid), 32'(1));
        @(negedge clk); check("bp_released", 32'(rsp_valid), 32'(0));

        // reset while the ALU is busy
        @(posedge clk); #1;
        req0_valid = 1'b1; req0_a = 8'h05; req0_b = 8'h06; req0_op = 4'h0;
        wait_grant(who, ok);
        @(posedge clk); #1 clear_reqs(); rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check("exec_rst_valid", 32'(rsp_valid), 32'(0));
        check("exec_rst_alu_a", 32'(alu_a), 32'(0));
        check("exec_rst_alu_op", 32'(alu_op), 32'(0));
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check("exec_rst_no_stale", 32'(rsp_valid), 32'(0));
        end
        @(posedge clk); #1 req0_valid = 1'b1; req1_valid = 1'b1;
        @(negedge clk);
        check("exec_rst_prio0_r0", 32'(req0_ready), 32'(1));
        check("exec_rst_prio0_r1", 32'(req1_ready), 32'(0));
        @(posedge clk); #1 clear_reqs();
        repeat (6) @(posedge clk);

        // randomized traffic against the model
        for (int c = 0; c < 800; c++) begin
            #1;
            rst        = ($urandom_range(0, 199) == 0);
            req0_valid = ($urandom_range(0, 99) < 65);
            req1_valid = ($urandom_range(0, 99) < 65);
            req0_a = 8'($urandom); req0_b = 8'($urandom); req0_op = 4'($urandom_range(0, 12));
            req1_a = 8'($urandom); req1_b = 8'($urandom); req1_op = 4'($urandom_range(0, 12));
            rsp_ready  = ($urandom_range(0, 99) < 70);
            @(posedge clk);
        end
        #1 rst = 1'b0; clear_reqs(); rsp_ready = 1'b1;
        repeat (10) @(posedge clk);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
